// File: rtl/minimax_pkg.sv
// Shared constants, types and helpers for the Connect-4 move generator.
package minimax_pkg;

   localparam int ROWS   = 6;
   localparam int COLS   = 7;
   localparam int GRID_W = ROWS * COLS * 2;
   localparam int CNT_W  = 3 * COLS;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] HUMAN = 2'b01;
   localparam logic [1:0] AI    = 2'b10;

   // Centre-first column preference.
   localparam int PREF_ORDER [COLS] = '{3, 2, 4, 1, 5, 0, 6};

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   function automatic int cell_msb(input int row, input int col);
      return 14 * row + 13 - 2 * col;
   endfunction

endpackage

// File: rtl/win_check.sv
// Combinational test: would dropping `piece` at (row, col) complete four in a row?
module win_check
   import minimax_pkg::*;
(
   input  logic [GRID_W-1:0] board,
   input  logic [2:0]        row,
   input  logic [2:0]        col,
   input  logic [1:0]        piece,
   output logic              hit
);

   // Directions: horizontal, vertical, diagonal, anti-diagonal.
   localparam int DR [4] = '{0, 1, 1,  1};
   localparam int DC [4] = '{1, 0, 1, -1};

   function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] b, input int r, input int c);
      logic [6:0] idx;
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return EMPTY;
      idx = 7'(cell_msb(r, c));
      return b[idx -: 2];
   endfunction

   // Length of the unbroken run of p next to (r, c) along (dr, dc), capped at 3.
   function automatic int run_len(input logic [GRID_W-1:0] b, input int r, input int c,
                                  input int dr, input int dc, input logic [1:0] p);
      int n;
      n = 0;
      for (int s = 1; s <= 3; s++) begin
         if (n == s - 1 && cell_at(b, r + s * dr, c + s * dc) == p) n = s;
      end
      return n;
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
      hit = 1'b0;
      for (int d = 0; d < 4; d++) begin
         if (1 + run_len(board, int'(row), int'(col),  DR[d],  DC[d], piece)
               + run_len(board, int'(row), int'(col), -DR[d], -DC[d], piece) >= 4)
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/minimax.sv
// AI move generator: snapshots the board, classifies one column per cycle, then picks a drop cell.
module minimax
   import minimax_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [GRID_W-1:0] grid,
   input  logic [CNT_W-1:0]  column_counts,
   input  logic              player,
   input  logic              sw,
   output logic [6:0]        opt,
   output logic              move
);

   state_t            state, state_d;
   logic [GRID_W-1:0] snap_grid;
   logic [CNT_W-1:0]  snap_counts;
   logic [2:0]        k;
   logic [COLS-1:0]   win_v, block_v, bad_v;

   logic              go;
   logic [2:0]        cnt [COLS];
   logic [COLS-1:0]   legal_v;
   logic [2:0]        cur_cnt;
   logic              cur_legal;
   logic [GRID_W-1:0] bad_board;
   logic              hit_win, hit_block, hit_bad;
   logic              win_now, block_now, bad_now;
   logic              found;
   logic [2:0]        sel, cand;
   logic [6:0]        opt_sel;

   assign go = sw & player;

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         cnt[c]     = snap_counts[3*c +: 3];
         legal_v[c] = cnt[c] < 3'd6;
      end
   end

   assign cur_cnt   = (k < 3'd7) ? cnt[k] : 3'd7;
   assign cur_legal = cur_cnt < 3'd6;

   // Board with the AI piece already dropped, for the "gives the human a four above" test.
   always_comb begin
      bad_board = snap_grid;
      if (cur_legal) bad_board[7'(cell_msb(int'(cur_cnt), int'(k))) -: 2] = AI;
   end

   win_check u_win   (.board(snap_grid), .row(cur_cnt),        .col(k), .piece(AI),    .hit(hit_win));
   win_check u_block (.board(snap_grid), .row(cur_cnt),        .col(k), .piece(HUMAN), .hit(hit_block));
   win_check u_bad   (.board(bad_board), .row(cur_cnt + 3'd1), .col(k), .piece(HUMAN), .hit(hit_bad));

   assign win_now   = cur_legal & hit_win;
   assign block_now = cur_legal & hit_block;
   assign bad_now   = cur_legal & (cur_cnt < 3'd5) & hit_bad;

   // Priority levels: win, block, safe legal, any legal; preference order within each.
   always_comb begin
      found = 1'b0;
      sel   = 3'd0;
      cand  = 3'd0;
      for (int lvl = 0; lvl < 4; lvl++) begin
         for (int i = 0; i < COLS; i++) begin
            cand = 3'(PREF_ORDER[i]);
            if (!found && ((lvl == 0 && win_v[cand])   ||
                           (lvl == 1 && block_v[cand]) ||
                           (lvl == 2 && legal_v[cand] && !bad_v[cand]) ||
                           (lvl == 3 && legal_v[cand]))) begin
               found = 1'b1;
               sel   = cand;
            end
         end
      end
   end

   assign opt_sel = 7'd13 - ({4'd0, sel} << 1) + {4'd0, cnt[sel]} * 7'd14;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (go) state_d = SCAN;
         SCAN:    if (!go) state_d = IDLE;
                  else if (k == 3'd7) state_d = DONE;
         DONE:    if (!go) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the snapshot and class flops are reset too, so nothing stale can leak into a choice.
      if (rst) begin
         snap_grid   <= '0;
         snap_counts <= '0;
         k           <= 3'd0;
         win_v       <= '0;
         block_v     <= '0;
         bad_v       <= '0;
         opt         <= 7'd0;
         move        <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= only, so every flop sees pre-edge values.
         case (state)
            IDLE: begin
               move <= 1'b0;
               if (go) begin
                  snap_grid   <= grid;
                  snap_counts <= column_counts;
                  k           <= 3'd0;
               end
            end
            SCAN: begin
               if (!go) begin
                  move <= 1'b0;
               end else if (k != 3'd7) begin
                  win_v[k]   <= win_now;
                  block_v[k] <= block_now;
                  bad_v[k]   <= bad_now;
                  k          <= k + 3'd1;
               end else begin
                  move <= found;
                  opt  <= found ? opt_sel : 7'd0;
               end
            end
            DONE:    if (!go) move <= 1'b0;
            default: move <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_minimax.sv
// Directed bench for the minimax move generator with hand-computed expected drop cells.
module tb_minimax;
   import minimax_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [83:0] grid;
   logic [20:0] column_counts;
   logic        player;
   logic        sw;
   logic [6:0]  opt;
   logic        move;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   minimax dut (
      .clk(clk), .rst(rst), .grid(grid), .column_counts(column_counts),
      .player(player), .sw(sw), .opt(opt), .move(move)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic clear_board();
      grid          = '0;
      column_counts = '0;
   endtask

   task automatic put(input int r, input int c, input logic [1:0] v);
      logic [6:0] i;
      i = 7'(14 * r + 13 - 2 * c);
      grid[i -: 2] = v;
   endtask

   task automatic set_count(input int c, input int n);
      logic [4:0] i;
      i = 5'(3 * c);
      column_counts[i +: 3] = 3'(n);
   endtask

   // Called just after a rising edge with the DUT idle.
   task automatic play(input string tag, input int exp_opt, input bit exp_move);
      sw = 1'b1; player = 1'b1;
      @(posedge clk);
      repeat (7) @(posedge clk);
      #1 check({tag, "/early"}, move, 0);
      @(posedge clk); #1;
      check({tag, "/move"}, move, exp_move);
      if (exp_move) check({tag, "/opt"}, opt, exp_opt);
      @(posedge clk); #1;
      check({tag, "/hold_move"}, move, exp_move);
      if (exp_move) check({tag, "/hold_opt"}, opt, exp_opt);
      player = 1'b0;
      @(posedge clk); #1;
      check({tag, "/release"}, move, 0);
      sw = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      bit seen;
      rst = 1'b1; player = 1'b0; sw = 1'b0;
      clear_board();
      #12;
      check("reset/move", move, 0);
      check("reset/opt", opt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      play("empty", 7, 1);

      clear_board();
      put(0, 0, AI); put(1, 0, AI); put(2, 0, AI); set_count(0, 3);
      play("win_col0", 55, 1);

      clear_board();
      put(0, 6, HUMAN); put(1, 6, HUMAN); put(2, 6, HUMAN); set_count(6, 3);
      play("block_col6", 43, 1);

      put(0, 0, AI); put(1, 0, AI); put(2, 0, AI); set_count(0, 3);
      play("win_over_block", 55, 1);

      clear_board();
      for (int r = 0; r < 6; r++) put(r, 3, (r % 2 == 0) ? HUMAN : AI);
      set_count(3, 6);
      play("col3_full", 9, 1);

      clear_board();
      put(0, 4, AI); put(0, 5, HUMAN); put(0, 6, AI);
      put(1, 4, HUMAN); put(1, 5, HUMAN); put(1, 6, HUMAN);
      set_count(4, 2); set_count(5, 2); set_count(6, 2);
      play("avoid_bad", 9, 1);

      clear_board();
      put(0, 3, AI); put(1, 4, AI); put(2, 5, AI);
      put(1, 5, AI); put(0, 6, AI); put(2, 6, AI);
      put(0, 4, HUMAN); put(0, 5, HUMAN); put(1, 6, HUMAN);
      set_count(3, 1); set_count(4, 2); set_count(5, 3); set_count(6, 3);
      play("diag_win", 43, 1);

      clear_board();
      for (int c = 0; c < 6; c++) set_count(c, 6);
      for (int r = 0; r < 5; r++) put(r, 6, (r % 2 == 0) ? HUMAN : AI);
      set_count(6, 5);
      play("top_row", 71, 1);

      clear_board();
      for (int c = 0; c < 7; c++) set_count(c, 6);
      play("all_full", 0, 0);

      // Reset in the middle of a scan.
      clear_board();
      play("empty_again", 7, 1);
      sw = 1'b1; player = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("rst_mid/move", move, 0);
      check("rst_mid/opt", opt, 0);
      #2 rst = 1'b0; sw = 1'b0; player = 1'b0;
      @(posedge clk); #1;

      // Turn withdrawn mid-scan.
      sw = 1'b1; player = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 player = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         seen |= move;
      end
      check("abort/move", seen, 0);
      sw = 1'b0;

      // vs-AI mode off.
      player = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         seen |= move;
      end
      check("sw_off/move", seen, 0);
      player = 1'b0;
      @(posedge clk); #1;

      play("recover", 7, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
